hazard_scoreboard: RTL and testbench

//  Parametrised scoreboard hazard unit; successor to the fixed two-source, two-stage compare unit.

---
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_hazard_scoreboard.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Issue/hazard bus between the ID stage and the scoreboard hazard unit.
//   master : ID stage. It drives the issue request and its source operands,
//            and receives the stall/hazard status back.
//   slave  : the scoreboard. It receives the request and drives the status.
// Signals:
//   issue_valid, issue_wb_en, issue_dest, issue_lat : the instruction requesting issue
//   src_valid, src                                  : source operands, src i at [i*RFD +: RFD]
//   stall, hazard_src, waw_hazard                   : combinational hazard status
//   pending, stall_count                            : per-register busy flags, stall statistics
interface hazard_scoreboard_if #(
  parameter int REG_FILE_DEPTH = 4,
  parameter int NUM_SRC        = 3,
  parameter int MAX_LAT        = 7
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic                              issue_valid;
  logic                              issue_wb_en;
  logic [REG_FILE_DEPTH-1:0]         issue_dest;
  logic [LAT_W-1:0]                  issue_lat;
  logic [NUM_SRC-1:0]                src_valid;
  logic [NUM_SRC*REG_FILE_DEPTH-1:0] src;
  logic                              stall;
  logic [NUM_SRC-1:0]                hazard_src;
  logic                              waw_hazard;
  logic [2**REG_FILE_DEPTH-1:0]      pending;
  logic [15:0]                       stall_count;

  modport master (
    output issue_valid, issue_wb_en, issue_dest, issue_lat, src_valid, src,
    input  stall, hazard_src, waw_hazard, pending, stall_count
  );

  modport slave (
    input  issue_valid, issue_wb_en, issue_dest, issue_lat, src_valid, src,
    output stall, hazard_src, waw_hazard, pending, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit placed beside the ID stage.
// Each register with an outstanding write has a countdown counter. The counter
// holds the number of cycles until the result can be used: forwardable when
// FWD_EN=1, written to the register file when FWD_EN=0. Issue is stalled when
// a used source is still counting down. Issue is also stalled when the new
// write would complete before an older write to the same destination.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; clears all tracking and stall_count
//   sb   : hazard_scoreboard_if.slave
//          issue_* and src* are inputs.
//          stall, hazard_src and waw_hazard are combinational outputs.
//          pending and stall_count are outputs.
module hazard_scoreboard #(
  parameter int REG_FILE_DEPTH = 4,
  parameter int NUM_SRC        = 3,
  parameter int MAX_LAT        = 7,
  parameter int WB_EXTRA       = 2,
  parameter int FWD_EN         = 1
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave sb
);

  localparam int NREG  = 2**REG_FILE_DEPTH;
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int CNT_W = $clog2(MAX_LAT + WB_EXTRA + 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [CNT_W-1:0] dec_sat0(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  // Without forwarding, consumers wait for the register-file write. That write
  // happens WB_EXTRA cycles after the result becomes forwardable.
  function automatic logic [CNT_W-1:0] load_of(input logic [LAT_W-1:0] lat);
    if (FWD_EN != 0) return CNT_W'(lat);
    else             return CNT_W'(lat) + CNT_W'(WB_EXTRA);
  endfunction

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [15:0]      stall_cnt_q;
  logic [15:0]      stall_cnt_d;

  logic [CNT_W-1:0]   load_val;
  logic [NUM_SRC-1:0] hazard_vec;
  logic               waw;
  logic               stall_w;
  logic               accept;
  logic [NREG-1:0]    pending_vec;

  // Hazard evaluation uses the pre-edge counters only. An instruction that
  // reads its own destination is therefore never blocked by its own load.
  always_comb begin
    load_val   = load_of(sb.issue_lat);
    hazard_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hazard_vec[i] = sb.src_valid[i] &
                      (cnt_q[sb.src[i*REG_FILE_DEPTH +: REG_FILE_DEPTH]] != '0);
    end
    // A strictly longer countdown would let the younger write finish first.
    waw     = sb.issue_wb_en & (cnt_q[sb.issue_dest] > load_val);
    stall_w = sb.issue_valid & ((|hazard_vec) | waw);
    accept  = sb.issue_valid & ~stall_w;
  end

  // A load overrides the decrement. A load of 0 clears the entry: any older
  // write still counting down is shorter and has been superseded.
  always_comb begin
    pending_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = dec_sat0(cnt_q[r]);
      if (accept && sb.issue_wb_en && (sb.issue_dest == REG_FILE_DEPTH'(r))) begin
        cnt_d[r] = load_val;
      end
      pending_vec[r] = (cnt_q[r] != '0);
    end
    stall_cnt_d = stall_w ? sat_inc16(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb.stall       = stall_w;
  assign sb.hazard_src  = hazard_vec;
  assign sb.waw_hazard  = waw;
  assign sb.pending     = pending_vec;
  assign sb.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_FILE_DEPTH(4), .NUM_SRC(3), .MAX_LAT(7)) if_f ();
  hazard_scoreboard_if #(.REG_FILE_DEPTH(4), .NUM_SRC(3), .MAX_LAT(7)) if_n ();

  hazard_scoreboard #(.REG_FILE_DEPTH(4), .NUM_SRC(3), .MAX_LAT(7),
                      .WB_EXTRA(2), .FWD_EN(1)) u_fwd (.clk(clk), .rst(rst), .sb(if_f));
  hazard_scoreboard #(.REG_FILE_DEPTH(4), .NUM_SRC(3), .MAX_LAT(7),
                      .WB_EXTRA(2), .FWD_EN(0)) u_nofwd (.clk(clk), .rst(rst), .sb(if_n));

  // issue_lat beyond MAX_LAT is illegal.
  always @(posedge clk) begin
    assert (if_f.issue_lat <= 3'd7 && if_n.issue_lat <= 3'd7)
      else $error("issue_lat out of range");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock. Inputs change and outputs are sampled shortly after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic v, input logic wb, input logic [3:0] d, input logic [2:0] lat,
                       input logic [2:0] sv, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2);
    if_f.issue_valid = v;  if_f.issue_wb_en = wb; if_f.issue_dest = d;
    if_f.issue_lat   = lat; if_f.src_valid  = sv; if_f.src        = {s2, s1, s0};
  endtask

  task automatic set_n(input logic v, input logic wb, input logic [3:0] d, input logic [2:0] lat,
                       input logic [2:0] sv, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2);
    if_n.issue_valid = v;  if_n.issue_wb_en = wb; if_n.issue_dest = d;
    if_n.issue_lat   = lat; if_n.src_valid  = sv; if_n.src        = {s2, s1, s0};
  endtask

  initial begin
    // reset with random issue/source activity
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_f(1'($urandom), 1'($urandom), 4'($urandom), 3'($urandom), 3'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom));
      set_n(1'($urandom), 1'($urandom), 4'($urandom), 3'($urandom), 3'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom));
      cyc();
    end
    chk("rst_pending",  32'(if_f.pending), 32'h0);
    chk("rst_stall",    32'(if_f.stall), 32'h0);
    chk("rst_hazsrc",   32'(if_f.hazard_src), 32'h0);
    chk("rst_waw",      32'(if_f.waw_hazard), 32'h0);
    chk("rst_stallcnt", 32'(if_f.stall_count), 32'h0);
    chk("rst_stallcnt_n", 32'(if_n.stall_count), 32'h0);
    chk("rst_stall_n",  32'(if_n.stall), 32'h0);
    set_f(0, 0, 0, 0, 0, 0, 0, 0);
    set_n(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc();

    // RAW, forwarding on: R3 lat=3, one idle cycle, then a reader of R3
    set_f(1, 1, 4'd3, 3'd3, 3'b000, 0, 0, 0);
    #1 chk("raw_issue_stall", 32'(if_f.stall), 32'h0);
    cyc();
    set_f(0, 0, 0, 0, 3'b001, 4'd3, 0, 0);
    #1 chk("raw_pend3", 32'(if_f.pending[3]), 32'h1);
    chk("idle_hazsrc", 32'(if_f.hazard_src), 32'h1);
    chk("idle_stall",  32'(if_f.stall), 32'h0);
    cyc();
    set_f(1, 0, 0, 0, 3'b001, 4'd3, 0, 0);
    #1 chk("raw_stall1", 32'(if_f.stall), 32'h1);
    chk("raw_hazsrc", 32'(if_f.hazard_src), 32'h1);
    cyc();
    chk("raw_stall2", 32'(if_f.stall), 32'h1);
    cyc();
    chk("raw_accept", 32'(if_f.stall), 32'h0);
    chk("raw_stallcnt", 32'(if_f.stall_count), 32'd2);
    cyc();
    set_f(0, 0, 0, 0, 0, 0, 0, 0);

    // RAW, forwarding off: R5 lat=1 -> counter 3, reader on source 1
    set_n(1, 1, 4'd5, 3'd1, 3'b000, 0, 0, 0);
    cyc();
    set_n(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("nf_pend5_a", 32'(if_n.pending[5]), 32'h1);
    cyc();
    set_n(1, 0, 0, 0, 3'b010, 0, 4'd5, 0);
    #1 chk("nf_stall1", 32'(if_n.stall), 32'h1);
    chk("nf_hazsrc", 32'(if_n.hazard_src), 32'h2);
    cyc();
    chk("nf_stall2", 32'(if_n.stall), 32'h1);
    chk("nf_pend5_b", 32'(if_n.pending[5]), 32'h1);
    cyc();
    chk("nf_accept", 32'(if_n.stall), 32'h0);
    chk("nf_pend5_c", 32'(if_n.pending[5]), 32'h0);
    chk("nf_stallcnt", 32'(if_n.stall_count), 32'd2);
    cyc();
    set_n(0, 0, 0, 0, 0, 0, 0, 0);

    // WAW: R2 lat=5, idle, then R2 lat=1 waits until cnt[2] reaches 1
    set_f(1, 1, 4'd2, 3'd5, 3'b000, 0, 0, 0);
    #1 chk("waw_first", 32'(if_f.stall), 32'h0);
    cyc();
    set_f(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    set_f(1, 1, 4'd2, 3'd1, 3'b000, 0, 0, 0);
    #1 chk("waw_flag", 32'(if_f.waw_hazard), 32'h1);
    chk("waw_stall1", 32'(if_f.stall), 32'h1);
    cyc();
    chk("waw_stall2", 32'(if_f.stall), 32'h1);
    cyc();
    chk("waw_stall3", 32'(if_f.stall), 32'h1);
    cyc();
    chk("waw_clear", 32'(if_f.waw_hazard), 32'h0);
    chk("waw_accept", 32'(if_f.stall), 32'h0);
    chk("waw_stallcnt", 32'(if_f.stall_count), 32'd5);
    cyc();
    set_f(0, 0, 0, 0, 0, 0, 0, 0);

    // Self-dependency: R4 reads and writes R4 with cnt[4]=0, so there is no stall
    set_f(1, 1, 4'd4, 3'd3, 3'b001, 4'd4, 0, 0);
    #1 chk("self_stall", 32'(if_f.stall), 32'h0);
    chk("self_hazsrc", 32'(if_f.hazard_src), 32'h0);
    cyc();
    // cnt[4]=3. A reload of 3 is accepted (3 > 3 is false) and overrides the decrement.
    set_f(1, 1, 4'd4, 3'd3, 3'b000, 0, 0, 0);
    #1 chk("reload_pend", 32'(if_f.pending[4]), 32'h1);
    chk("reload_stall", 32'(if_f.stall), 32'h0);
    cyc();
    set_f(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("reload_hold", 32'(if_f.pending[4]), 32'h1);
    cyc();
    chk("reload_done", 32'(if_f.pending[4]), 32'h0);
    chk("stallcnt_kept", 32'(if_f.stall_count), 32'd5);

    // Saturation: steady self-dependent R1 reissue, 9 stalls per 10 cycles
    set_n(1, 1, 4'd1, 3'd7, 3'b001, 4'd1, 0, 0);
    for (int k = 0; k < 74000; k++) cyc();
    chk("sat_value", 32'(if_n.stall_count), 32'hFFFF);
    for (int k = 0; k < 30; k++) cyc();
    chk("sat_hold", 32'(if_n.stall_count), 32'hFFFF);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1 chk("midrst_pending", 32'(if_n.pending), 32'h0);
    chk("midrst_stallcnt", 32'(if_n.stall_count), 32'h0);
    chk("midrst_stall", 32'(if_n.stall), 32'h0);
    cyc();
    chk("postrst_load", 32'(if_n.pending[1]), 32'h1);
    set_n(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
